// File: rtl/simd_sat_accum.sv
// Packed-SIMD running accumulator: 4x8 / 2x16 / 1x32 signed segments with
// optional saturation and sticky per-byte-lane overflow, valid/ready in and out.
module simd_sat_accum #(
   parameter int CNT_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [CNT_W-1:0] i_num_terms,
   input  logic [1:0]       i_width,
   input  logic             i_saturate,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [31:0]      i_in_data,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [31:0]      o_acc_out,
   output logic [3:0]       o_ovf_sticky,
   output logic             o_busy
);

   // state   | meaning
   // S_IDLE  | waiting for start
   // S_ACCUM | accepting operands until the term counter hits one
   // S_DONE  | result held on acc_out until out_ready

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic [31:0]      r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic [3:0]       r_ovf;
   logic [1:0]       r_width;
   logic             r_sat;

   logic             w_accept;
   logic [31:0]      w_sum;
   logic [3:0]       w_seg_ovf;
   logic [8:0]       w_b8 [4];
   logic [16:0]      w_h16 [2];
   logic [32:0]      w_w32;

   // Each helper returns {overflow, result}; overflow is reported even when clamping.
   function automatic logic [8:0] sadd8(input logic [7:0] a, input logic [7:0] b,
                                        input logic sat);
      logic [7:0] s;
      logic       ovf;
      s   = a + b;
      ovf = (a[7] == b[7]) && (s[7] != a[7]);
      if (ovf && sat) s = a[7] ? 8'h80 : 8'h7F;
      return {ovf, s};
   endfunction

   function automatic logic [16:0] sadd16(input logic [15:0] a, input logic [15:0] b,
                                          input logic sat);
      logic [15:0] s;
      logic        ovf;
      s   = a + b;
      ovf = (a[15] == b[15]) && (s[15] != a[15]);
      if (ovf && sat) s = a[15] ? 16'h8000 : 16'h7FFF;
      return {ovf, s};
   endfunction

   function automatic logic [32:0] sadd32(input logic [31:0] a, input logic [31:0] b,
                                          input logic sat);
      logic [31:0] s;
      logic        ovf;
      s   = a + b;
      ovf = (a[31] == b[31]) && (s[31] != a[31]);
      if (ovf && sat) s = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      return {ovf, s};
   endfunction

   for (genvar k = 0; k < 4; k++) begin : g_b8
      assign w_b8[k] = sadd8(r_acc[8*k +: 8], i_in_data[8*k +: 8], r_sat);
   end
   for (genvar k = 0; k < 2; k++) begin : g_h16
      assign w_h16[k] = sadd16(r_acc[16*k +: 16], i_in_data[16*k +: 16], r_sat);
   end
   assign w_w32 = sadd32(r_acc, i_in_data, r_sat);

   always_comb begin
      w_sum     = r_acc;
      w_seg_ovf = '0;
      case (r_width)
         2'b00: begin
            w_sum     = {w_b8[3][7:0], w_b8[2][7:0], w_b8[1][7:0], w_b8[0][7:0]};
            w_seg_ovf = {w_b8[3][8], w_b8[2][8], w_b8[1][8], w_b8[0][8]};
         end
         2'b01: begin
            w_sum     = {w_h16[1][15:0], w_h16[0][15:0]};
            w_seg_ovf = {{2{w_h16[1][16]}}, {2{w_h16[0][16]}}};
         end
         default: begin
            w_sum     = w_w32[31:0];
            w_seg_ovf = {4{w_w32[32]}};
         end
      endcase
   end

   assign w_accept = (r_state == S_ACCUM) && i_in_valid;

   // Handshake outputs decode the registered state only.
   always_comb begin
      w_next_state = r_state;
      o_in_ready   = 1'b0;
      o_out_valid  = 1'b0;
      o_busy       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start) w_next_state = (i_num_terms != '0) ? S_ACCUM : S_DONE;
         end
         S_ACCUM: begin
            o_in_ready = 1'b1;
            o_busy     = 1'b1;
            if (i_in_valid && (r_cnt == CNT_W'(1))) w_next_state = S_DONE;
         end
         S_DONE: begin
            o_out_valid = 1'b1;
            o_busy      = 1'b1;
            if (i_out_ready) w_next_state = S_IDLE;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_acc   <= '0;
         r_cnt   <= '0;
         r_ovf   <= '0;
         r_width <= '0;
         r_sat   <= 1'b0;
      end else if ((r_state == S_IDLE) && i_start) begin
         r_width <= i_width;
         r_sat   <= i_saturate;
         r_cnt   <= i_num_terms;
         r_acc   <= '0;
         r_ovf   <= '0;
      end else if (w_accept) begin
         r_acc <= w_sum;
         r_ovf <= r_ovf | w_seg_ovf;
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   assign o_acc_out    = r_acc;
   assign o_ovf_sticky = r_ovf;

endmodule

// File: tb/tb_simd_sat_accum.sv
// Bench for simd_sat_accum: directed and random jobs, results checked by a
// scoreboard against an integer-arithmetic segment model.
module tb_simd_sat_accum;
   localparam int CNT_W = 8;

   logic             i_clk = 1'b0;
   logic             i_rst;
   logic             i_start;
   logic [CNT_W-1:0] i_num_terms;
   logic [1:0]       i_width;
   logic             i_saturate;
   logic             i_in_valid;
   logic             o_in_ready;
   logic [31:0]      i_in_data;
   logic             o_out_valid;
   logic             i_out_ready;
   logic [31:0]      o_acc_out;
   logic [3:0]       o_ovf_sticky;
   logic             o_busy;

   int          n_vec = 0;
   int          n_err = 0;
   int          n_accepts = 0;
   logic [35:0] exp_q[$];
   logic [31:0] ops[$];

   simd_sat_accum #(.CNT_W(CNT_W)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_num_terms(i_num_terms),
      .i_width(i_width), .i_saturate(i_saturate), .i_in_valid(i_in_valid),
      .o_in_ready(o_in_ready), .i_in_data(i_in_data), .o_out_valid(o_out_valid),
      .i_out_ready(i_out_ready), .o_acc_out(o_acc_out), .o_ovf_sticky(o_ovf_sticky),
      .o_busy(o_busy)
   );

   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) if (i_in_valid && o_in_ready) n_accepts <= n_accepts + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Segments treated as signed integers; overflow is leaving the representable range.
   function automatic void model_add(inout logic [31:0] acc, inout logic [3:0] ovf,
                                     input logic [31:0] op, input logic [1:0] w,
                                     input bit sat);
      int     nb;
      longint lim, m, av, bv, sum, full;
      nb   = (w == 2'b00) ? 8 : (w == 2'b01) ? 16 : 32;
      lim  = longint'(1) << (nb - 1);
      m    = (longint'(1) << nb) - 1;
      full = longint'(acc);
      for (int s = 0; s < 32 / nb; s++) begin
         av = (longint'(acc) >> (s * nb)) & m;
         bv = (longint'(op) >> (s * nb)) & m;
         if (av >= lim) av = av - 2 * lim;
         if (bv >= lim) bv = bv - 2 * lim;
         sum = av + bv;
         if (sum >= lim || sum < -lim) begin
            for (int l = s * nb / 8; l < (s + 1) * nb / 8; l++) ovf[l] = 1'b1;
            if (sat) sum = (sum > 0) ? lim - 1 : -lim;
         end
         full = (full & ~(m << (s * nb))) | ((sum & m) << (s * nb));
      end
      acc = full[31:0];
   endfunction

   task automatic send_op(input logic [31:0] d);
      int budget;
      budget     = 0;
      i_in_valid = 1'b1;
      i_in_data  = d;
      while (!o_in_ready && budget < 20) begin
         @(posedge i_clk); #1;
         budget++;
      end
      if (!o_in_ready) begin
         n_vec++;
         n_err++;
         $display("FAIL in_ready_timeout: got 0 expected 1");
      end else begin
         @(posedge i_clk); #1;
      end
      i_in_valid = 1'b0;
   endtask

   // gap < 0 selects random 0..2 idle cycles before each operand.
   task automatic run_job(input int n, input logic [1:0] w, input bit sat, input int gap,
                          input int hold, input bit chk_const, input logic [31:0] c_acc,
                          input logic [3:0] c_ovf);
      logic [31:0] m_acc;
      logic [3:0]  m_ovf;
      int          acc0, g;
      m_acc = '0;
      m_ovf = '0;
      for (int i = 0; i < n; i++) model_add(m_acc, m_ovf, ops[i], w, sat);
      exp_q.push_back({m_ovf, m_acc});
      acc0        = n_accepts;
      i_start     = 1'b1;
      i_num_terms = CNT_W'(n);
      i_width     = w;
      i_saturate  = sat;
      @(posedge i_clk); #1;
      i_start     = 1'b0;
      i_num_terms = CNT_W'($urandom);
      i_width     = 2'($urandom);
      i_saturate  = 1'($urandom);
      for (int i = 0; i < n; i++) begin
         g = (gap >= 0) ? gap : int'($urandom_range(0, 2));
         for (int j = 0; j < g; j++) begin
            i_in_valid = 1'b0;
            i_in_data  = $urandom;
            @(posedge i_clk); #1;
         end
         send_op(ops[i]);
      end
      chk("out_valid_rise", 32'(o_out_valid), 32'd1);
      chk("busy_done", 32'(o_busy), 32'd1);
      chk("accept_count", 32'(n_accepts - acc0), 32'(n));
      chk("acc_at_done", o_acc_out, m_acc);
      chk("ovf_at_done", 32'(o_ovf_sticky), 32'(m_ovf));
      if (chk_const) begin
         chk("acc_plan", o_acc_out, c_acc);
         chk("ovf_plan", 32'(o_ovf_sticky), 32'(c_ovf));
      end
      for (int i = 0; i < hold; i++) begin
         i_start     = 1'($urandom);
         i_num_terms = CNT_W'($urandom);
         @(posedge i_clk); #1;
         chk("hold_valid", 32'(o_out_valid), 32'd1);
         chk("hold_acc", o_acc_out, m_acc);
      end
      i_start     = 1'b0;
      i_out_ready = 1'b1;
      @(posedge i_clk); #1;
      i_out_ready = 1'b0;
      chk("back_to_idle", 32'(o_out_valid), 32'd0);
      chk("busy_idle", 32'(o_busy), 32'd0);
   endtask

   initial begin
      fork
         begin : monitor
            logic [35:0] e;
            forever begin
               @(negedge i_clk);
               if (!i_rst && o_out_valid && i_out_ready) begin
                  if (exp_q.size() == 0) begin
                     n_vec++;
                     n_err++;
                     $display("FAIL unexpected_result: got %h with no expected entry", o_acc_out);
                  end else begin
                     e = exp_q.pop_front();
                     chk("sb_acc", o_acc_out, e[31:0]);
                     chk("sb_ovf", 32'(o_ovf_sticky), 32'(e[35:32]));
                  end
               end
            end
         end
         begin : watchdog
            #2000000;
            $display("FAIL watchdog: simulation time limit reached");
            $fatal(1, "watchdog");
         end
         begin : stimulus
            i_rst = 1'b1; i_start = 1'b0; i_num_terms = '0; i_width = '0;
            i_saturate = 1'b0; i_in_valid = 1'b0; i_in_data = '0; i_out_ready = 1'b0;
            repeat (3) @(posedge i_clk);
            #1;
            i_rst = 1'b0;
            chk("rst_acc", o_acc_out, 32'd0);
            chk("rst_ovf", 32'(o_ovf_sticky), 32'd0);
            chk("rst_in_ready", 32'(o_in_ready), 32'd0);
            chk("rst_out_valid", 32'(o_out_valid), 32'd0);
            chk("rst_busy", 32'(o_busy), 32'd0);

            ops = '{32'h7010F080, 32'h2010F080};
            run_job(2, 2'b00, 1'b1, 0, 0, 1'b1, 32'h7F20E080, 4'b1001);
            run_job(2, 2'b00, 1'b0, 1, 0, 1'b1, 32'h9020E000, 4'b1001);
            ops = '{32'h7FFF0001, 32'h0001FFFF};
            run_job(2, 2'b01, 1'b1, 0, 0, 1'b1, 32'h7FFF0000, 4'b1100);
            ops = '{32'h7FFFFFFF, 32'h00000001};
            run_job(2, 2'b10, 1'b1, 0, 0, 1'b1, 32'h7FFFFFFF, 4'b1111);
            run_job(2, 2'b10, 1'b0, 0, 0, 1'b1, 32'h80000000, 4'b1111);
            run_job(2, 2'b11, 1'b0, 0, 0, 1'b1, 32'h80000000, 4'b1111);
            ops = '{$urandom, $urandom, $urandom};
            run_job(3, 2'b00, 1'b1, 2, 5, 1'b0, 32'h0, 4'h0);
            run_job(0, 2'b01, 1'b1, 0, 0, 1'b1, 32'h0, 4'h0);

            // Reset after one of three accepts discards the partial sum.
            i_start = 1'b1; i_num_terms = CNT_W'(3); i_width = 2'b00; i_saturate = 1'b0;
            @(posedge i_clk); #1;
            i_start = 1'b0;
            send_op(32'h7F7F7F7F);
            i_rst = 1'b1; i_in_valid = 1'b1; i_in_data = 32'h11111111;
            @(posedge i_clk); #1;
            i_rst = 1'b0; i_in_valid = 1'b0;
            chk("midrst_acc", o_acc_out, 32'd0);
            chk("midrst_ovf", 32'(o_ovf_sticky), 32'd0);
            chk("midrst_in_ready", 32'(o_in_ready), 32'd0);
            chk("midrst_busy", 32'(o_busy), 32'd0);
            ops = '{32'h01020304};
            run_job(1, 2'b00, 1'b0, 0, 0, 1'b1, 32'h01020304, 4'h0);

            for (int j = 0; j < 40; j++) begin
               int n;
               n = int'($urandom_range(0, 6));
               ops.delete();
               for (int i = 0; i < n; i++) ops.push_back($urandom);
               run_job(n, 2'($urandom), 1'($urandom), -1, int'($urandom_range(0, 3)),
                       1'b0, 32'h0, 4'h0);
            end

            chk("sb_drained", 32'(exp_q.size()), 32'd0);
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
            $finish;
         end
      join
   end

endmodule
